// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage with a single-outstanding memory interface and
//   an IF/ID pipeline register.
//
//   State table:
//     state     | meaning
//     ----------+-------------------------------------------------------------
//     S_ISSUE   | no request outstanding; issue a request for pc_f when allowed
//     S_WAIT    | one request outstanding; its data is wanted
//     S_HOLD    | data returned while decode stalled; parked in the hold buffer
//     S_DISCARD | one request outstanding whose data must be dropped (redirect)
//
//   Ports:
//     clk, rst_n               clock, synchronous active-low reset
//     stall_f, stall_d         fetch / decode stalls from the hazard unit
//     flush_d                  load a bubble into IF/ID
//     pc_src, pc_target_e      redirect from execute
//     imem_req, imem_addr      request strobe and address (combinational)
//     imem_rvalid, imem_rdata  response strobe and instruction
//     instr_d, pc_d,
//     pc_plus4_d, valid_d      IF/ID register contents
//     pc_f                     current fetch PC
module fetch_unit #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_f,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  pc_src,
    input  logic [DATA_WIDTH-1:0] pc_target_e,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic [DATA_WIDTH-1:0] pc_f
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [DATA_WIDTH-1:0] hold_buf_q, hold_buf_d;
    logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
    logic [DATA_WIDTH-1:0] pc_d_q, pc_d_d;
    logic [DATA_WIDTH-1:0] pc_plus4_d_q, pc_plus4_d_d;
    logic                  valid_d_q, valid_d_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] deliver_data;
    logic                  req;
    logic [DATA_WIDTH-1:0] req_addr;

    // Wraps naturally at 2^DATA_WIDTH.
    assign pc_plus4 = pc_f_q + DATA_WIDTH'(4);

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        hold_buf_d   = hold_buf_q;
        deliver      = 1'b0;
        deliver_data = hold_buf_q;
        req          = 1'b0;
        req_addr     = pc_f_q;

        unique case (state_q)
            S_ISSUE: begin
                if (pc_src) begin
                    pc_f_d = pc_target_e;
                end else if (!stall_f) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_src) begin
                    pc_f_d  = pc_target_e;
                    state_d = imem_rvalid ? S_ISSUE : S_DISCARD;
                end else if (imem_rvalid) begin
                    if (!stall_d) begin
                        // Accept and immediately request the next word so a
                        // 1-cycle memory sustains one instruction per cycle.
                        deliver      = 1'b1;
                        deliver_data = imem_rdata;
                        pc_f_d       = pc_plus4;
                        req          = 1'b1;
                        req_addr     = pc_plus4;
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (pc_src) begin
                    pc_f_d  = pc_target_e;
                    state_d = S_ISSUE;
                end else if (!stall_d) begin
                    deliver = 1'b1;
                    pc_f_d  = pc_plus4;
                    state_d = S_ISSUE;
                end
            end
            S_DISCARD: begin
                // A redirect here replaces any earlier target; still waiting
                // for the stale response to drain before issuing again.
                if (pc_src) begin
                    pc_f_d = pc_target_e;
                end
                if (imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase

        if (flush_d) begin
            instr_d_d    = NOP_INSTR;
            pc_d_d       = '0;
            pc_plus4_d_d = '0;
            valid_d_d    = 1'b0;
        end else if (stall_d) begin
            instr_d_d    = instr_d_q;
            pc_d_d       = pc_d_q;
            pc_plus4_d_d = pc_plus4_d_q;
            valid_d_d    = valid_d_q;
        end else if (deliver) begin
            instr_d_d    = deliver_data;
            pc_d_d       = pc_f_q;
            pc_plus4_d_d = pc_plus4;
            valid_d_d    = 1'b1;
        end else begin
            instr_d_d    = NOP_INSTR;
            pc_d_d       = '0;
            pc_plus4_d_d = '0;
            valid_d_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_ISSUE;
            pc_f_q       <= RESET_PC;
            hold_buf_q   <= '0;
            instr_d_q    <= NOP_INSTR;
            pc_d_q       <= '0;
            pc_plus4_d_q <= '0;
            valid_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            hold_buf_q   <= hold_buf_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    // The strobe must be low while reset is held, even though the state
    // register only clears on the edge.
    assign imem_req   = req & rst_n;
    assign imem_addr  = req_addr;
    assign instr_d    = instr_d_q;
    assign pc_d       = pc_d_q;
    assign pc_plus4_d = pc_plus4_d_q;
    assign valid_d    = valid_d_q;
    assign pc_f       = pc_f_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Randomized and directed checks of fetch_unit against a flag-based
//   reference model of the fetch rules and a variable-latency memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall_f, stall_d, flush_d, pc_src;
    logic [31:0] pc_target_e;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d, pc_d, pc_plus4_d, pc_f;
    logic        valid_d;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src      (pc_src),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .pc_f        (pc_f)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory environment
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat  = 1;   // 0 selects a random latency of 1..3

    // reference model
    bit          m_wait, m_drop, m_held, m_valid;
    logic [31:0] m_pc, m_buf, m_instr, m_pcd, m_pc4;

    // per-cycle observations and expectations
    bit          exp_req, obs_req;
    logic [31:0] exp_addr, obs_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs at the negedge, sample combinational
    // outputs, advance model and memory after the posedge.
    task automatic step(input bit rst, input bit sf, input bit sd, input bit fl,
                        input bit ps, input logic [31:0] tgt, input bit inj);
        bit          idle, deliver, n_wait, n_drop, n_held, n_valid, rv;
        logic [31:0] dval, n_pc, n_buf, n_instr, n_pcd, n_pc4;
        @(negedge clk);
        rst_n       = rst;
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
        pc_src      = ps;
        pc_target_e = tgt;
        rv          = (mem_busy && mem_cnt == 1) || inj;
        imem_rvalid = rv;
        imem_rdata  = inj ? 32'hDEAD_BEEF : (rv ? mem_data(mem_addr) : $urandom());
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;

        idle     = !(m_wait || m_drop || m_held);
        exp_req  = rst && ((idle && !ps && !sf) || (m_wait && rv && !ps && !sd));
        exp_addr = idle ? m_pc : m_pc + 32'd4;

        deliver = 1'b0;
        dval    = m_buf;
        if (m_wait && rv && !ps && !sd) begin
            deliver = 1'b1;
            dval    = imem_rdata;
        end else if (m_held && !ps && !sd) begin
            deliver = 1'b1;
        end

        n_wait = 1'b0; n_drop = 1'b0; n_held = 1'b0; n_buf = m_buf;
        if (idle) begin
            n_wait = !ps && !sf;
        end else if (m_wait) begin
            if (ps)          n_drop = !rv;
            else if (!rv)    n_wait = 1'b1;
            else if (sd) begin
                n_held = 1'b1;
                n_buf  = imem_rdata;
            end else         n_wait = 1'b1;
        end else if (m_drop) begin
            n_drop = !rv;
        end else begin
            n_held = !ps && sd;
        end

        n_pc = ps ? tgt : (deliver ? m_pc + 32'd4 : m_pc);

        if (fl) begin
            n_instr = NOP; n_pcd = 0; n_pc4 = 0; n_valid = 0;
        end else if (sd) begin
            n_instr = m_instr; n_pcd = m_pcd; n_pc4 = m_pc4; n_valid = m_valid;
        end else if (deliver) begin
            n_instr = dval; n_pcd = m_pc; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
        end else begin
            n_instr = NOP; n_pcd = 0; n_pc4 = 0; n_valid = 0;
        end

        @(posedge clk);
        #1;
        if (!rst) begin
            m_wait = 0; m_drop = 0; m_held = 0; m_pc = RST_PC; m_buf = 0;
            m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
            mem_busy = 1'b0;
        end else begin
            m_wait = n_wait; m_drop = n_drop; m_held = n_held; m_pc = n_pc; m_buf = n_buf;
            m_instr = n_instr; m_pcd = n_pcd; m_pc4 = n_pc4; m_valid = n_valid;
            if (mem_busy) begin
                if (mem_cnt == 1) mem_busy = 1'b0;
                else              mem_cnt--;
            end
            if (obs_req) begin
                mem_busy = 1'b1;
                mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
                mem_addr = obs_addr;
            end
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        mem_lat = 1;
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (obs_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req got %b exp 0", obs_req);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({pc_f, instr_d, pc_d, pc_plus4_d, valid_d} !== {RST_PC, NOP, 32'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals got %h %h %h %h %b exp %h %h 0 0 0",
                     pc_f, instr_d, pc_d, pc_plus4_d, valid_d, RST_PC, NOP);
        end
    endtask

    task automatic test_stream();
        bit          r0, r1, r2;
        logic [31:0] a0, a1, a2;
        mem_lat = 1;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0); r0 = obs_req; a0 = obs_addr;
        n_tests++;
        if (valid_d !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_valid_c1 got %b exp 0", valid_d);
        end
        step(1, 0, 0, 0, 0, 0, 0); r1 = obs_req; a1 = obs_addr;
        n_tests++;
        if ({instr_d, pc_d, pc_plus4_d, valid_d} !== {mem_data(RST_PC), RST_PC, RST_PC + 32'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_ifid got %h %h %h %b exp %h %h %h 1",
                     instr_d, pc_d, pc_plus4_d, valid_d, mem_data(RST_PC), RST_PC, RST_PC + 32'd4);
        end
        step(1, 0, 0, 0, 0, 0, 0); r2 = obs_req; a2 = obs_addr;
        n_tests++;
        if ({r0, a0, r1, a1, r2, a2} !== {1'b1, 32'hBFC0_0000, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0008}) begin
            n_fail++;
            $display("FAIL stream_addrs got %b%h %b%h %b%h exp 1bfc00000 1bfc00004 1bfc00008",
                     r0, a0, r1, a1, r2, a2);
        end
    endtask

    task automatic test_hold();
        logic [31:0] a0, a4;
        a0 = RST_PC;
        a4 = RST_PC + 32'd4;
        mem_lat = 1;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);   // response for a4 arrives under stall
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (obs_req !== 1'b0 || pc_f !== a4 ||
                {instr_d, pc_d, pc_plus4_d, valid_d} !== {mem_data(a0), a0, a4, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got req %b pc_f %h ifid %h %h %h %b exp req 0 pc_f %h ifid %h %h %h 1",
                         i, obs_req, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, a4, mem_data(a0), a0, a4);
            end
            step(1, 0, (i < 2), 0, 0, 0, 0);
        end
        // last step above released the stall
        n_tests++;
        if (obs_req !== 1'b0 ||
            {instr_d, pc_d, pc_plus4_d, valid_d} !== {mem_data(a4), a4, a4 + 32'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_release got req %b ifid %h %h %h %b exp req 0 ifid %h %h %h 1",
                     obs_req, instr_d, pc_d, pc_plus4_d, valid_d, mem_data(a4), a4, a4 + 32'd4);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({obs_req, obs_addr} !== {1'b1, a4 + 32'd4}) begin
            n_fail++;
            $display("FAIL hold_next_req got %b %h exp 1 %h", obs_req, obs_addr, a4 + 32'd4);
        end
    endtask

    task automatic test_discard();
        bit r3, r4;
        mem_lat = 3;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h0000_0100, 0);
        n_tests++;
        if (obs_req !== 1'b0 || pc_f !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL discard_redirect got req %b pc_f %h exp req 0 pc_f 00000100", obs_req, pc_f);
        end
        step(1, 0, 0, 0, 0, 0, 0); r3 = obs_req;
        step(1, 0, 0, 0, 0, 0, 0); r4 = obs_req;   // late response arrives here
        n_tests++;
        if ({r3, r4, valid_d} !== 3'b000) begin
            n_fail++;
            $display("FAIL discard_drop got req %b %b valid %b exp 0 0 0", r3, r4, valid_d);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({obs_req, obs_addr} !== {1'b1, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL discard_next_req got %b %h exp 1 00000100", obs_req, obs_addr);
        end
    endtask

    task automatic test_same_cycle();
        mem_lat = 1;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 32'h0000_0200, 0);
        n_tests++;
        if (obs_req !== 1'b0 || {instr_d, valid_d, pc_f} !== {NOP, 1'b0, 32'h0000_0200}) begin
            n_fail++;
            $display("FAIL same_cycle_regs got req %b %h %b %h exp req 0 00000013 0 00000200",
                     obs_req, instr_d, valid_d, pc_f);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({obs_req, obs_addr} !== {1'b1, 32'h0000_0200}) begin
            n_fail++;
            $display("FAIL same_cycle_req got %b %h exp 1 00000200", obs_req, obs_addr);
        end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_req got %b %h exp 1 fffffffc", obs_req, obs_addr);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({obs_req, obs_addr, instr_d, pc_d, pc_plus4_d, valid_d} !==
            {1'b1, 32'h0, mem_data(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_ifid got req %b %h ifid %h %h %h %b exp req 1 00000000 ifid %h fffffffc 00000000 1",
                     obs_req, obs_addr, instr_d, pc_d, pc_plus4_d, valid_d, mem_data(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_lat = 3;
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (obs_req !== 1'b0 ||
            {pc_f, instr_d, pc_d, pc_plus4_d, valid_d} !== {RST_PC, NOP, 32'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_vals got req %b %h %h %h %h %b exp req 0 %h %h 0 0 0",
                     obs_req, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, RST_PC, NOP);
        end
        step(1, 0, 0, 0, 0, 0, 1);   // stale response right after release
        n_tests++;
        if ({obs_req, obs_addr, valid_d} !== {1'b1, RST_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_first_req got %b %h valid %b exp 1 %h valid 0",
                     obs_req, obs_addr, valid_d, RST_PC);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({obs_req, valid_d} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_after got req %b valid %b exp 0 0", obs_req, valid_d);
        end
    endtask

    task automatic test_random();
        bit          r, sf, sd, fl, ps;
        logic [31:0] tgt;
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) != 0);
            sf  = ($urandom_range(0, 9) == 0);
            sd  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            ps  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step(r, sf, sd, fl, ps, tgt, 0);
            n_tests++;
            if ({obs_req, obs_req ? obs_addr : 32'd0} !== {exp_req, exp_req ? exp_addr : 32'd0}) begin
                n_fail++;
                $display("FAIL rand_req cycle %0d got %b %h exp %b %h",
                         i, obs_req, obs_addr, exp_req, exp_addr);
            end
            n_tests++;
            if ({pc_f, instr_d, pc_d, pc_plus4_d, valid_d} !== {m_pc, m_instr, m_pcd, m_pc4, m_valid}) begin
                n_fail++;
                $display("FAIL rand_regs cycle %0d got %h %h %h %h %b exp %h %h %h %h %b",
                         i, pc_f, instr_d, pc_d, pc_plus4_d, valid_d,
                         m_pc, m_instr, m_pcd, m_pc4, m_valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src = 1'b0;
        pc_target_e = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        test_reset();
        test_stream();
        test_hold();
        test_discard();
        test_same_cycle();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
